// File: rtl/core_dmem_resp.sv
// Single-port data memory responder: one request at a time, fixed LATENCY to rsp_valid,
// byte-strobed stores, and an access-fault flag for addresses outside the array window.
module core_dmem_resp #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH_LOG2 = 12,
  parameter logic [XLEN-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned     LATENCY    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  input  logic              req_wen,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_wen
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [XLEN:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [XLEN:0] LIMIT_EXT = BASE_EXT + ((XLEN + 1)'(1) << (DEPTH_LOG2 + 2));

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              wen_q, wen_d;
  logic [XLEN-1:0]   mem_q [DEPTH];

  logic                  accept;
  logic                  fault;
  logic [XLEN:0]         addr_ext;
  logic [DEPTH_LOG2-1:0] idx;

  // Extra top bit keeps the limit compare from wrapping when the window ends at 2^XLEN.
  assign addr_ext = {1'b0, req_addr};
  assign fault    = (addr_ext < BASE_EXT) || (addr_ext >= LIMIT_EXT);
  assign idx      = DEPTH_LOG2'((req_addr - BASE_ADDR) >> 2);
  assign accept   = req_valid && (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wen_d   = wen_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wen_d   = req_wen;
          err_d   = fault;
          rdata_d = (req_wen || fault) ? '0 : mem_q[idx];
          cnt_d   = CNT_INIT;
          state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
    end
  end

  // Array contents survive reset; stores commit at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && req_wen && !fault) begin
      for (int i = 0; i < NB; i++) begin
        if (req_wmask[i]) mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign rsp_wen   = wen_q;

endmodule

// File: tb/tb_core_dmem_resp.sv
// Bench for core_dmem_resp: LATENCY=1 and LATENCY=3 instances checked against a byte-level memory model.
module tb_core_dmem_resp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        req_wen   [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wmask [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        rsp_wen   [2];

  core_dmem_resp #(.XLEN(32), .DEPTH_LOG2(12), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_wen(req_wen[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .rsp_wen(rsp_wen[0])
  );

  core_dmem_resp #(.XLEN(32), .DEPTH_LOG2(12), .BASE_ADDR(32'h8000_0000), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_wen(req_wen[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .rsp_wen(rsp_wen[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference memory: word data plus which bytes have ever been written.
  logic [31:0] mm [2][4096];
  logic [3:0]  kb [2][4096];

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic logic is_fault(input logic [31:0] addr);
    longint a;
    a = longint'(addr);
    return (a < 64'h8000_0000) || (a >= 64'h8000_0000 + 64'd16384);
  endfunction

  function automatic int word_idx(input logic [31:0] addr);
    return int'(((addr - 32'h8000_0000) >> 2) & 32'h0000_0FFF);
  endfunction

  task automatic model_store(input int u, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wm);
    int idx;
    idx = word_idx(addr);
    if (!is_fault(addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (wm[b]) begin
          mm[u][idx][8*b +: 8] = wd[8*b +: 8];
          kb[u][idx][b] = 1'b1;
        end
      end
    end
  endtask

  task automatic do_req(input int u, input logic [31:0] addr, input logic wen, input logic [31:0] wd,
                        input logic [3:0] wm, input int hold, input string nm);
    logic        flt;
    int          idx;
    int          n;
    logic [31:0] exp_d, bm, held;
    flt   = is_fault(addr);
    idx   = word_idx(addr);
    exp_d = 32'h0;
    bm    = 32'hFFFF_FFFF;
    if (!wen && !flt) begin
      exp_d = mm[u][idx];
      for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{kb[u][idx][b]}};
    end
    if (wen) model_store(u, addr, wd, wm);

    checks++;
    if (req_ready[u] !== 1'b1) begin
      errors++; $display("FAIL %s u%0d idle req_ready got %b want 1", nm, u, req_ready[u]);
    end
    req_valid[u] = 1'b1; req_addr[u] = addr; req_wen[u] = wen; req_wdata[u] = wd; req_wmask[u] = wm;
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    n = 0;
    while (rsp_valid[u] !== 1'b1 && n < 20) begin
      checks++;
      if (req_ready[u] !== 1'b0) begin
        errors++; $display("FAIL %s u%0d wait req_ready got %b want 0", nm, u, req_ready[u]);
      end
      req_valid[u] = 1'($urandom); req_addr[u] = $urandom; req_wen[u] = 1'($urandom);
      req_wdata[u] = $urandom; req_wmask[u] = 4'($urandom); rsp_ready[u] = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    rsp_ready[u] = 1'b0;
    checks++;
    if (n != lat_of(u) - 1) begin
      errors++; $display("FAIL %s u%0d latency got %0d want %0d", nm, u, n + 1, lat_of(u));
    end
    checks++;
    if ((rsp_rdata[u] & bm) !== (exp_d & bm)) begin
      errors++; $display("FAIL %s u%0d rdata got %h want %h", nm, u, rsp_rdata[u], exp_d);
    end
    checks++;
    if (rsp_err[u] !== flt || rsp_wen[u] !== wen) begin
      errors++; $display("FAIL %s u%0d err/wen got %b/%b want %b/%b", nm, u, rsp_err[u], rsp_wen[u], flt, wen);
    end
    held = rsp_rdata[u];
    for (int h = 0; h < hold; h++) begin
      req_valid[u] = 1'($urandom); req_addr[u] = $urandom; req_wen[u] = 1'($urandom);
      req_wdata[u] = $urandom; req_wmask[u] = 4'($urandom);
      @(posedge clk); #1;
      checks++;
      if (rsp_valid[u] !== 1'b1 || rsp_rdata[u] !== held || req_ready[u] !== 1'b0) begin
        errors++; $display("FAIL %s u%0d hold v/rdy/rdata got %b/%b/%h want 1/0/%h", nm, u,
                           rsp_valid[u], req_ready[u], rsp_rdata[u], held);
      end
    end
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[u] = 1'b0;
    checks++;
    if (rsp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
      errors++; $display("FAIL %s u%0d release valid/ready got %b/%b want 0/1", nm, u, rsp_valid[u], req_ready[u]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_addr[u] = 32'h0; req_wen[u] = 1'b0;
      req_wdata[u] = 32'h0; req_wmask[u] = 4'h0; rsp_ready[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (req_ready[u] !== 1'b1 || rsp_valid[u] !== 1'b0 || rsp_rdata[u] !== 32'h0 ||
          rsp_err[u] !== 1'b0 || rsp_wen[u] !== 1'b0) begin
        errors++; $display("FAIL reset u%0d rdy/v/rdata/err/wen got %b/%b/%h/%b/%b want 1/0/0/0/0",
                           u, req_ready[u], rsp_valid[u], rsp_rdata[u], rsp_err[u], rsp_wen[u]);
      end
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    for (int u = 0; u < 2; u++) begin
      do_req(u, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'b1111, 0, "store_full");
      do_req(u, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, "load_full");
    end
  endtask

  task automatic test_byte_strobe();
    for (int u = 0; u < 2; u++) begin
      do_req(u, 32'h8000_0012, 1'b1, 32'h0000_AA00, 4'b0010, 0, "store_byte");
      do_req(u, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, "load_byte");
      checks++;
      if (mm[u][4] !== 32'hDEAD_AAEF) begin
        errors++; $display("FAIL byte_model u%0d got %h want deadaaef", u, mm[u][4]);
      end
      do_req(u, 32'h8000_0010, 1'b1, 32'h1234_5678, 4'b0000, 0, "store_nomask");
      do_req(u, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, "load_nomask");
    end
  endtask

  task automatic test_backpressure();
    for (int u = 0; u < 2; u++) begin
      do_req(u, 32'h8000_0020, 1'b1, 32'hCAFE_F00D, 4'b1111, 0, "bp_store");
      do_req(u, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 5, "bp_load");
      do_req(u, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 0, "bp_reload");
    end
  endtask

  task automatic test_fault();
    for (int u = 0; u < 2; u++) begin
      do_req(u, 32'h8000_0000, 1'b1, 32'h0BAD_0000, 4'b1111, 0, "edge_w0");
      do_req(u, 32'h8000_3FFC, 1'b1, 32'h0BAD_0FFF, 4'b1111, 0, "edge_w4095");
      do_req(u, 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, "fault_load_low");
      do_req(u, 32'h8000_4000, 1'b1, 32'hFFFF_FFFF, 4'b1111, 0, "fault_store_high");
      do_req(u, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFF, 4'b1111, 0, "fault_store_top");
      do_req(u, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, "reload_w0");
      do_req(u, 32'h8000_3FFC, 1'b0, 32'h0, 4'h0, 0, "reload_w4095");
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 9) < 2) begin
          addr = ($urandom_range(0, 1) == 1) ? 32'h8000_4000 + $urandom_range(0, 4000)
                                             : 32'h7FFF_F000 + $urandom_range(0, 4095);
        end else begin
          addr = 32'h8000_0000 + 32'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7)
                                                                 : $urandom_range(4088, 4095)) * 4
                 + $urandom_range(0, 3);
        end
        do_req(u, addr, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), "random");
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    model_store(1, 32'h8000_0100, 32'h1234_5678, 4'b1111);
    req_valid[1] = 1'b1; req_addr[1] = 32'h8000_0100; req_wen[1] = 1'b1;
    req_wdata[1] = 32'h1234_5678; req_wmask[1] = 4'b1111;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    n = 0;
    while (rsp_valid[1] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (rsp_valid[1] !== 1'b1) begin
      errors++; $display("FAIL rst_mid_reach_resp got %b want 1", rsp_valid[1]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1 || rsp_wen[1] !== 1'b0) begin
      errors++; $display("FAIL rst_mid valid/ready/wen got %b/%b/%b want 0/1/0", rsp_valid[1], req_ready[1], rsp_wen[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid[1] !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after valid got %b want 0", rsp_valid[1]);
    end
    do_req(1, 32'h8000_0100, 1'b0, 32'h0, 4'h0, 0, "rst_mid_reload");
  endtask

  initial begin
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 4096; i++) begin
        mm[u][i] = 32'h0;
        kb[u][i] = 4'h0;
      end
    test_reset();
    test_store_load();
    test_byte_strobe();
    test_backpressure();
    test_fault();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
